core_bus_sequencer: RTL and testbench

//  Multi-cycle bus sequencer between the RV32I datapath/controller and separate instruction/data buses.

---
 rtl/core_bus_sequencer_if.sv | 38 +++
 rtl/core_bus_sequencer.sv | 158 +++++++++++++++
 tb/tb_core_bus_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_bus_sequencer_if.sv
// Instruction/data bus bundle between core_bus_sequencer and the memories.
// Latency: none (wires only).
// Backpressure: req is held with a stable address until the slave returns ack.
// Ports (master = sequencer side):
//   ibus_req/ibus_addr out, ibus_ack/ibus_rdata in                  -- instruction fetch
//   dbus_req/dbus_we/dbus_addr/dbus_wdata/dbus_type out,
//   dbus_ack/dbus_rdata in                                          -- data load/store
interface core_bus_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
);
  logic              ibus_req;
  logic [ADDR_W-1:0] ibus_addr;
  logic              ibus_ack;
  logic [XLEN-1:0]   ibus_rdata;

  logic              dbus_req;
  logic              dbus_we;
  logic [XLEN-1:0]   dbus_addr;
  logic [XLEN-1:0]   dbus_wdata;
  logic [2:0]        dbus_type;
  logic              dbus_ack;
  logic [XLEN-1:0]   dbus_rdata;

  modport master (
    output ibus_req, ibus_addr,
    input  ibus_ack, ibus_rdata,
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_type,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  ibus_req, ibus_addr,
    output ibus_ack, ibus_rdata,
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_type,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/core_bus_sequencer.sv
// Multi-cycle RV32I bus sequencer: fetch -> exec -> (mem -> wb) with req/ack buses, timeout and fault/halt.
// Latency with zero-wait memories: 2 cycles per ALU/branch instruction, 4 cycles per load/store.
// Backpressure: memories stall by withholding ack; a req unanswered for TIMEOUT cycles halts with a sticky fault.
// Ports:
//   clk, reset (sync, active-high); pc, mem_read, mem_write, mem_addr, mem_wdata, rw_type from datapath/controller
//   bus (core_bus_sequencer_if.master): ibus_* fetch and dbus_* data handshakes
//   instr, rd_data (registered), commit (retire pulse), busy, fault (00 none, 01 ibus, 10 dbus, 11 misaligned)
// Optional: define SEQ_MISALIGN_CHECK_EN to halt on misaligned halfword/word accesses instead of issuing them.
module core_bus_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     pc,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [XLEN-1:0]       mem_addr,
  input  logic [XLEN-1:0]       mem_wdata,
  input  logic [2:0]            rw_type,
  core_bus_sequencer_if.master  bus,
  output logic [XLEN-1:0]       instr,
  output logic [XLEN-1:0]       rd_data,
  output logic                  commit,
  output logic                  busy,
  output logic [1:0]            fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);
  // Last count value on which an ack is still accepted.
  localparam logic [7:0]      CNT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0]      FAULT_IBUS = 2'b01;
  localparam logic [1:0]      FAULT_DBUS = 2'b10;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
  logic [1:0]        fault_q, fault_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              mem_acc;

  assign mem_acc = mem_read | mem_write;

`ifdef SEQ_MISALIGN_CHECK_EN
  localparam logic [1:0] FAULT_ALIGN = 2'b11;
  logic misaligned;
  // Byte accesses (rw_type[1:0]=00) can never be misaligned.
  assign misaligned = mem_acc &&
                      (((rw_type[1:0] == 2'b01) && mem_addr[0]) ||
                       ((rw_type[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= NOP_INSTR;
      rd_data_q <= '0;
      fault_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rd_data_q <= rd_data_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rd_data_d = rd_data_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FETCH: begin
        if (bus.ibus_ack) begin
          instr_d = bus.ibus_rdata;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = FAULT_IBUS;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        cnt_d = '0;
        if (!mem_acc) begin
          state_d = S_FETCH;
        end else begin
`ifdef SEQ_MISALIGN_CHECK_EN
          if (misaligned) begin
            fault_d = FAULT_ALIGN;
            state_d = S_HALT;
          end else begin
            state_d = S_MEM;
          end
`else
          state_d = S_MEM;
`endif
        end
      end
      S_MEM: begin
        if (bus.dbus_ack) begin
          // Store wins when both strobes are set, so only pure loads capture data.
          if (!mem_write) rd_data_d = bus.dbus_rdata;
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = FAULT_DBUS;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic (Moore on state, address/data passed straight from the datapath)
  always_comb begin
    bus.ibus_req   = (state_q == S_FETCH);
    bus.ibus_addr  = pc;
    bus.dbus_req   = (state_q == S_MEM);
    bus.dbus_we    = mem_write;
    bus.dbus_addr  = mem_addr;
    bus.dbus_wdata = mem_wdata;
    bus.dbus_type  = rw_type;
    commit         = ((state_q == S_EXEC) && !mem_acc) || (state_q == S_WB);
    busy           = (state_q != S_IDLE) && (state_q != S_HALT);
  end

  assign instr   = instr_q;
  assign rd_data = rd_data_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_core_bus_sequencer.sv
module tb_core_bus_sequencer;
  localparam int ADDR_W  = 8;
  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  localparam logic [31:0] W_ADD  = 32'h0020_81B3;
  localparam logic [31:0] W_LW   = 32'h1000_2183;
  localparam logic [31:0] W_SW   = 32'h2020_2023;
  localparam logic [31:0] W_ADDI = 32'h0010_0093;
  localparam logic [31:0] W_LH   = 32'h1010_1183;
  localparam logic [31:0] W_LB   = 32'h1010_0183;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] pc;
  logic              mem_read, mem_write;
  logic [XLEN-1:0]   mem_addr, mem_wdata;
  logic [2:0]        rw_type;
  logic [XLEN-1:0]   instr, rd_data;
  logic              commit, busy;
  logic [1:0]        fault;

  int total = 0;
  int bad   = 0;

  core_bus_sequencer_if #(.ADDR_W(ADDR_W), .XLEN(XLEN)) bus_if ();

  core_bus_sequencer #(.ADDR_W(ADDR_W), .XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .rw_type   (rw_type),
    .bus       (bus_if),
    .instr     (instr),
    .rd_data   (rd_data),
    .commit    (commit),
    .busy      (busy),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    pc = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0; rw_type = 3'b010;
    bus_if.ibus_ack = 1'b0; bus_if.ibus_rdata = '0;
    bus_if.dbus_ack = 1'b0; bus_if.dbus_rdata = '0;
    tick(); tick();

    // Reset state
    chk("rst_ibus_req", 32'(bus_if.ibus_req), 32'd0);
    chk("rst_dbus_req", 32'(bus_if.dbus_req), 32'd0);
    chk("rst_busy",     32'(busy),   32'd0);
    chk("rst_commit",   32'(commit), 32'd0);
    chk("rst_instr",    instr,       32'h0000_0013);
    chk("rst_rd_data",  rd_data,     32'd0);
    chk("rst_fault",    32'(fault),  32'd0);

    // 1: ADD, ack in first req cycle (ack already high in IDLE must be ignored)
    pc = 8'h04; bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_ADD;
    reset = 1'b0;
    tick();  // -> FETCH
    chk("t1_ibus_req",  32'(bus_if.ibus_req),  32'd1);
    chk("t1_ibus_addr", 32'(bus_if.ibus_addr), 32'h04);
    chk("t1_busy",      32'(busy),             32'd1);
    chk("t1_instr_pre", instr,                 32'h0000_0013);
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    #1;
    chk("t1_instr",     instr,                 W_ADD);
    chk("t1_commit",    32'(commit),           32'd1);
    chk("t1_ireq_exec", 32'(bus_if.ibus_req),  32'd0);
    pc = 8'h08;
    tick();  // -> FETCH
    chk("t1_commit_off", 32'(commit),          32'd0);
    chk("t1_next_addr",  32'(bus_if.ibus_addr), 32'h08);
    chk("t1_next_req",   32'(bus_if.ibus_req),  32'd1);

    // 2: LW 0x100, 3 wait states
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_LW;
    mem_read = 1'b1; mem_addr = 32'h100; rw_type = 3'b010;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    #1;
    chk("t2_instr",       instr,               W_LW);
    chk("t2_exec_commit", 32'(commit),         32'd0);
    chk("t2_exec_dreq",   32'(bus_if.dbus_req), 32'd0);
    tick();  // -> MEM cycle 1
    chk("t2_dreq",  32'(bus_if.dbus_req), 32'd1);
    chk("t2_dwe",   32'(bus_if.dbus_we),  32'd0);
    chk("t2_daddr", bus_if.dbus_addr,     32'h100);
    chk("t2_dtype", 32'(bus_if.dbus_type), 32'd2);
    tick(); tick(); tick();  // MEM cycle 4
    chk("t2_dreq_held",   32'(bus_if.dbus_req), 32'd1);
    chk("t2_wait_commit", 32'(commit),          32'd0);
    chk("t2_rd_pre",      rd_data,              32'd0);
    bus_if.dbus_ack = 1'b1; bus_if.dbus_rdata = 32'hDEAD_BEEF;
    tick();  // -> WB (7th cycle of the instruction)
    bus_if.dbus_ack = 1'b0;
    #1;
    chk("t2_wb_commit", 32'(commit),          32'd1);
    chk("t2_wb_rd",     rd_data,              32'hDEAD_BEEF);
    chk("t2_wb_dreq",   32'(bus_if.dbus_req), 32'd0);
    mem_read = 1'b0; pc = 8'h0C;
    tick();  // -> FETCH
    chk("t2_after_commit", 32'(commit),  32'd0);
    chk("t2_rd_hold",      rd_data,      32'hDEAD_BEEF);

    // 3: store with both strobes set
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_SW;
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234_5678;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    #1;
    chk("t3_exec_commit", 32'(commit), 32'd0);
    tick();  // -> MEM
    chk("t3_dreq",   32'(bus_if.dbus_req), 32'd1);
    chk("t3_dwe",    32'(bus_if.dbus_we),  32'd1);
    chk("t3_dwdata", bus_if.dbus_wdata,    32'h1234_5678);
    bus_if.dbus_ack = 1'b1; bus_if.dbus_rdata = 32'hCAFE_F00D;
    tick();  // -> WB
    bus_if.dbus_ack = 1'b0;
    #1;
    chk("t3_commit",  32'(commit), 32'd1);
    chk("t3_rd_keep", rd_data,     32'hDEAD_BEEF);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();  // -> FETCH
    chk("t3_one_commit", 32'(commit), 32'd0);

    // 4a: ack on the 16th req cycle is still accepted
    repeat (TIMEOUT - 1) tick();
    chk("t4a_req16",   32'(bus_if.ibus_req), 32'd1);
    chk("t4a_fault16", 32'(fault),           32'd0);
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_ADDI;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    #1;
    chk("t4a_instr",  instr,       W_ADDI);
    chk("t4a_commit", 32'(commit), 32'd1);
    chk("t4a_fault",  32'(fault),  32'd0);
    tick();  // -> FETCH

    // 4b: no ack for 16 req cycles -> ibus timeout
    repeat (TIMEOUT - 1) tick();
    chk("t4b_req16",  32'(bus_if.ibus_req), 32'd1);
    chk("t4b_busy16", 32'(busy),            32'd1);
    tick();  // -> HALT
    chk("t4b_fault", 32'(fault),           32'd1);
    chk("t4b_busy",  32'(busy),            32'd0);
    chk("t4b_req",   32'(bus_if.ibus_req), 32'd0);
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_ADD;
    tick(); tick(); tick();
    chk("t4b_halt_commit", 32'(commit),           32'd0);
    chk("t4b_halt_req",    32'(bus_if.ibus_req),  32'd0);
    chk("t4b_halt_instr",  instr,                 W_ADDI);
    chk("t4b_halt_fault",  32'(fault),            32'd1);
    bus_if.ibus_ack = 1'b0;

    // 5: reset while in MEM with dbus_req high
    reset = 1'b1;
    tick();
    chk("t5_rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;
    tick();  // -> FETCH
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_LW;
    mem_read = 1'b1; mem_addr = 32'h100;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    tick();  // -> MEM
    chk("t5_mem_dreq", 32'(bus_if.dbus_req), 32'd1);
    reset = 1'b1; bus_if.dbus_ack = 1'b1; bus_if.dbus_rdata = 32'h5555_5555;
    tick();  // -> IDLE
    chk("t5_dreq",   32'(bus_if.dbus_req), 32'd0);
    chk("t5_commit", 32'(commit),          32'd0);
    chk("t5_instr",  instr,                32'h0000_0013);
    chk("t5_rd",     rd_data,              32'd0);
    chk("t5_ireq0",  32'(bus_if.ibus_req), 32'd0);
    reset = 1'b0; bus_if.dbus_ack = 1'b0;
    tick();  // -> FETCH
    chk("t5_ireq_resume", 32'(bus_if.ibus_req), 32'd1);

    // 6: LH at odd address
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_LH;
    mem_read = 1'b1; rw_type = 3'b001; mem_addr = 32'h101;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    tick();
`ifdef SEQ_MISALIGN_CHECK_EN
    chk("t6_lh_dreq",  32'(bus_if.dbus_req), 32'd0);
    chk("t6_lh_fault", 32'(fault),           32'd3);
    chk("t6_lh_busy",  32'(busy),            32'd0);
`else
    chk("t6_lh_dreq",  32'(bus_if.dbus_req), 32'd1);
    chk("t6_lh_daddr", bus_if.dbus_addr,     32'h101);
    chk("t6_lh_fault", 32'(fault),           32'd0);
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();  // -> FETCH

    // 6b: LB at odd address always proceeds
    bus_if.ibus_ack = 1'b1; bus_if.ibus_rdata = W_LB;
    rw_type = 3'b000; mem_addr = 32'h101;
    tick();  // -> EXEC
    bus_if.ibus_ack = 1'b0;
    tick();  // -> MEM
    chk("t6_lb_dreq",  32'(bus_if.dbus_req), 32'd1);
    chk("t6_lb_daddr", bus_if.dbus_addr,     32'h101);
    bus_if.dbus_ack = 1'b1; bus_if.dbus_rdata = 32'h0000_00A5;
    tick();  // -> WB
    bus_if.dbus_ack = 1'b0;
    #1;
    chk("t6_lb_commit", 32'(commit), 32'd1);
    chk("t6_lb_rd",     rd_data,     32'h0000_00A5);
    chk("t6_lb_fault",  32'(fault),  32'd0);
    mem_read = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
